// File: rtl/nar_pkg.sv
// Shared Q1.6 fixed-point definitions for the neuron forward/backward datapaths.
package nar_pkg;
    localparam int DATA_W    = 8;
    localparam int FRAC_BITS = 6;
    localparam int Q_MAX     = 127;
    localparam int Q_MIN     = -128;

    typedef logic signed [DATA_W-1:0] q_t;

    typedef enum logic {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } bp_state_t;
endpackage

// File: rtl/q_mul_sat.sv
// Combinational Q1.6 saturating multiply: (a*b) >>> FRAC_BITS clamped to the Q1.6 range.
module q_mul_sat
    import nar_pkg::*;
(
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic [DATA_W-1:0] p,
    output logic              sat
);
    localparam logic signed [2*DATA_W-1:0] PROD_MAX = (2*DATA_W)'(Q_MAX);
    localparam logic signed [2*DATA_W-1:0] PROD_MIN = (2*DATA_W)'(Q_MIN);

    logic signed [2*DATA_W-1:0] prod;
    logic signed [2*DATA_W-1:0] scaled;

    always_comb begin
        prod   = $signed(a) * $signed(b);
        scaled = prod >>> FRAC_BITS;
        p      = scaled[DATA_W-1:0];
        sat    = 1'b0;
        if (scaled > PROD_MAX) begin
            p   = DATA_W'(Q_MAX);
            sat = 1'b1;
        end else if (scaled < PROD_MIN) begin
            p   = DATA_W'(Q_MIN);
            sat = 1'b1;
        end
    end
endmodule

// File: rtl/neuron_backprop.sv
// Per-neuron backward pass: streams (w,x) pairs, emits updated weights and bias.
// Optional back-propagated error output enabled by NEURON_BP_ERR_EN.
module neuron_backprop
    import nar_pkg::*;
#(
    parameter int N_IN     = 4,
    parameter int LR_SHIFT = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [DATA_W-1:0] delta_in,
    input  logic [DATA_W-1:0] b_in,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] w_in,
    input  logic [DATA_W-1:0] x_in,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] w_out,
`ifdef NEURON_BP_ERR_EN
    output logic [DATA_W-1:0] err_out,
`endif
    output logic              out_last,
    output logic [DATA_W-1:0] b_out,
    output logic              busy,
    output logic              done,
    output logic              ovr
);
    localparam int CW = $clog2(N_IN + 1);
    localparam logic signed [DATA_W:0] DIFF_MAX = (DATA_W+1)'(Q_MAX);
    localparam logic signed [DATA_W:0] DIFF_MIN = (DATA_W+1)'(Q_MIN);

    // Returns {sat_flag, value} for a - s computed at DATA_W+1 bits.
    function automatic logic [DATA_W:0] sat_sub(input q_t a, input q_t s);
        logic signed [DATA_W:0] diff;
        diff = {a[DATA_W-1], a} - {s[DATA_W-1], s};
        if (diff > DIFF_MAX)
            return {1'b1, DATA_W'(Q_MAX)};
        else if (diff < DIFF_MIN)
            return {1'b1, DATA_W'(Q_MIN)};
        else
            return {1'b0, diff[DATA_W-1:0]};
    endfunction

    bp_state_t state, state_next;
    logic [CW-1:0] idx_in, idx_out;
    q_t delta_r;

    logic in_fire, out_fire, pass_end;
    logic [DATA_W-1:0] g_raw;
    logic g_sat;
    q_t g, g_step, bias_step;
    logic [DATA_W:0] w_res, b_res;
    logic pair_sat;

    assign busy     = (state != IDLE);
    assign out_last = out_valid && (idx_out == CW'(N_IN - 1));
    assign in_ready = (state == STREAM) && (idx_in < CW'(N_IN)) && (!out_valid || out_ready);
    assign in_fire  = in_valid && in_ready;
    assign out_fire = out_valid && out_ready;
    assign pass_end = out_fire && out_last;

    q_mul_sat u_grad (
        .a   (delta_r),
        .b   (x_in),
        .p   (g_raw),
        .sat (g_sat)
    );

    always_comb begin
        g         = $signed(g_raw);
        g_step    = g >>> LR_SHIFT;
        bias_step = $signed(delta_in) >>> LR_SHIFT;
        w_res     = sat_sub($signed(w_in), g_step);
        b_res     = sat_sub($signed(b_in), bias_step);
    end

`ifdef NEURON_BP_ERR_EN
    logic [DATA_W-1:0] err_val;
    logic err_sat;

    q_mul_sat u_err (
        .a   (w_in),
        .b   (delta_r),
        .p   (err_val),
        .sat (err_sat)
    );

    assign pair_sat = g_sat | w_res[DATA_W] | err_sat;
`else
    assign pair_sat = g_sat | w_res[DATA_W];
`endif

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = STREAM;
            STREAM:  if (pass_end) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            delta_r   <= '0;
            idx_in    <= '0;
            idx_out   <= '0;
            out_valid <= 1'b0;
            w_out     <= '0;
            b_out     <= '0;
            done      <= 1'b0;
            ovr       <= 1'b0;
`ifdef NEURON_BP_ERR_EN
            err_out   <= '0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        delta_r   <= $signed(delta_in);
                        b_out     <= b_res[DATA_W-1:0];
                        ovr       <= b_res[DATA_W];
                        idx_in    <= '0;
                        idx_out   <= '0;
                        out_valid <= 1'b0;
                    end
                end
                STREAM: begin
                    if (out_fire) idx_out <= idx_out + 1'b1;
                    if (pass_end) done <= 1'b1;
                    // A new pair can land in the same cycle the previous result drains.
                    if (in_fire) begin
                        out_valid <= 1'b1;
                        w_out     <= w_res[DATA_W-1:0];
                        idx_in    <= idx_in + 1'b1;
                        ovr       <= ovr | pair_sat;
`ifdef NEURON_BP_ERR_EN
                        err_out   <= err_val;
`endif
                    end else if (out_fire) begin
                        out_valid <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_neuron_backprop.sv
// Directed bench for neuron_backprop (N_IN=4, LR_SHIFT=3); err_out checked when NEURON_BP_ERR_EN is set.
module tb_neuron_backprop;
    logic clk = 1'b0;
    logic rst, start, in_valid, out_ready;
    logic [7:0] delta_in, b_in, w_in, x_in;
    logic in_ready, out_valid, out_last, busy, done, ovr;
    logic [7:0] w_out, b_out;
`ifdef NEURON_BP_ERR_EN
    logic [7:0] err_out;
`endif
    int total = 0;
    int passed = 0;

    neuron_backprop #(.N_IN(4), .LR_SHIFT(3)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .delta_in  (delta_in),
        .b_in      (b_in),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .w_in      (w_in),
        .x_in      (x_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .w_out     (w_out),
`ifdef NEURON_BP_ERR_EN
        .err_out   (err_out),
`endif
        .out_last  (out_last),
        .b_out     (b_out),
        .busy      (busy),
        .done      (done),
        .ovr       (ovr)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, " in_ready"}, int'(in_ready), 0);
        chk({tag, " out_valid"}, int'(out_valid), 0);
        chk({tag, " w_out"}, int'($signed(w_out)), 0);
        chk({tag, " b_out"}, int'($signed(b_out)), 0);
        chk({tag, " out_last"}, int'(out_last), 0);
        chk({tag, " busy"}, int'(busy), 0);
        chk({tag, " done"}, int'(done), 0);
        chk({tag, " ovr"}, int'(ovr), 0);
`ifdef NEURON_BP_ERR_EN
        chk({tag, " err_out"}, int'($signed(err_out)), 0);
`endif
    endtask

    task automatic do_start(input int d, input int b);
        start = 1'b1; delta_in = 8'(d); b_in = 8'(b);
        tick();
        start = 1'b0;
    endtask

    // Push one pair with out_ready high and check the registered result.
    task automatic push(input string tag, input int w, input int x,
                        input int exp_w, input int exp_err, input int exp_last);
        in_valid = 1'b1; w_in = 8'(w); x_in = 8'(x);
        tick();
        in_valid = 1'b0;
        chk({tag, " out_valid"}, int'(out_valid), 1);
        chk({tag, " w_out"}, int'($signed(w_out)), exp_w);
        chk({tag, " out_last"}, int'(out_last), exp_last);
`ifdef NEURON_BP_ERR_EN
        chk({tag, " err_out"}, int'($signed(err_out)), exp_err);
`else
        if (exp_err == 9999) $display("unused");
`endif
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        delta_in = '0; b_in = '0; w_in = '0; x_in = '0;
        tick(); tick();
        chk_reset("reset");
        rst = 1'b0;
        tick();
        chk("idle busy", int'(busy), 0);

        // Basic update and streaming; pair offered together with start must be ignored.
        in_valid = 1'b1; w_in = 8'd99; x_in = 8'd64;
        do_start(64, 10);
        in_valid = 1'b0;
        chk("basic busy", int'(busy), 1);
        chk("basic b_out", int'($signed(b_out)), 2);
        chk("basic ovr", int'(ovr), 0);
        chk("basic no pair with start", int'(out_valid), 0);
        chk("basic in_ready", int'(in_ready), 1);
        push("s0", 32, 64, 24, 32, 0);
        push("s1", -64, 32, -68, -64, 0);
        push("s2", 100, -64, 108, 100, 0);
        push("s3", 0, 127, -15, 0, 1);
        chk("s3 in_ready", int'(in_ready), 0);
        tick();
        chk("basic done", int'(done), 1);
        chk("basic busy end", int'(busy), 0);
        chk("basic out_valid end", int'(out_valid), 0);
        chk("basic ovr end", int'(ovr), 0);
        tick();
        chk("basic done pulse", int'(done), 0);

        // Saturation: gradient saturates, weight clamps, ovr sticky.
        do_start(-128, 0);
        chk("sat b_out", int'($signed(b_out)), 16);
        chk("sat ovr clear", int'(ovr), 0);
        push("t0", -128, -128, -128, 127, 0);
        chk("sat ovr set", int'(ovr), 1);
        push("t1", 0, 0, 0, 0, 0);
        chk("sat ovr sticky1", int'(ovr), 1);
        push("t2", 0, 0, 0, 0, 0);
        push("t3", 0, 0, 0, 0, 1);
        tick();
        chk("sat done", int'(done), 1);
        chk("sat ovr after done", int'(ovr), 1);

        // Backpressure: hold the first result for 3 cycles.
        do_start(64, 0);
        chk("bp b_out", int'($signed(b_out)), -8);
        chk("bp ovr cleared", int'(ovr), 0);
        out_ready = 1'b0;
        in_valid = 1'b1; w_in = 8'd32; x_in = 8'd64;
        tick();
        chk("bp first valid", int'(out_valid), 1);
        chk("bp first w", int'($signed(w_out)), 24);
        w_in = 8'd16; x_in = 8'd0;
        for (int i = 0; i < 3; i++) begin
            chk("bp in_ready low", int'(in_ready), 0);
            tick();
            chk("bp hold valid", int'(out_valid), 1);
            chk("bp hold w", int'($signed(w_out)), 24);
`ifdef NEURON_BP_ERR_EN
            chk("bp hold err", int'($signed(err_out)), 32);
`endif
        end
        out_ready = 1'b1;
        tick();
        chk("bp second w", int'($signed(w_out)), 16);
        chk("bp second last", int'(out_last), 0);
        push("b2", 8, 0, 8, 8, 0);
        push("b3", 4, 0, 4, 4, 1);
        tick();
        chk("bp done", int'(done), 1);

        // Ignored start mid-pass, then reset after 2 of 4 pairs.
        do_start(64, 10);
        push("i0", 32, 64, 24, 32, 0);
        start = 1'b1; delta_in = 8'(-64); b_in = 8'd50;
        push("i1", 32, 64, 24, 32, 0);
        start = 1'b0;
        chk("ign b_out", int'($signed(b_out)), 2);
        chk("ign busy", int'(busy), 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk_reset("midrst");
        tick();
        chk("midrst no done", int'(done), 0);
        chk("midrst idle", int'(busy), 0);

        // Fresh pass after reset, including positive weight saturation.
        do_start(-64, 50);
        chk("post b_out", int'($signed(b_out)), 58);
        push("p0", 32, 64, 40, -32, 0);
        chk("post ovr0", int'(ovr), 0);
        push("p1", 127, 127, 127, -127, 0);
        chk("post ovr1", int'(ovr), 1);
        push("p2", 0, 0, 0, 0, 0);
        push("p3", -10, 64, -2, 10, 1);
        tick();
        chk("post done", int'(done), 1);
        chk("post busy", int'(busy), 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/neuron_backprop.md
# neuron_backprop

Backward-pass companion to the forward neuron datapath: for one neuron it streams the N_IN (weight, input) pairs used in the forward pass, applies a gradient-descent update with the neuron's output error `delta`, and returns updated weights, a back-propagated error per input and an updated bias. All values use the same 8-bit signed Q1.6 fixed-point format as the forward path, with saturation. It sits between the training controller and the weight memory, one instance per neuron, with valid/ready streams on both sides.

## Interface
- `N_IN`, 4: number of weight/input pairs per pass (≥1)
- `LR_SHIFT`, 3: learning rate = 2^-LR_SHIFT (0..7)
- `clk` in 1: single clock, rising edge
- `rst` in 1: synchronous, active-high reset
- `start` in 1: begin pass; sampled only in IDLE
- `delta_in` in 8: signed Q1.6 output error, captured on `start`
- `b_in` in 8: signed Q1.6 current bias, captured on `start`
- `in_valid` in 1 / `in_ready` out 1: input pair handshake
- `w_in`, `x_in` in 8 each: signed Q1.6 weight and forward input
- `out_valid` out 1 / `out_ready` in 1: result handshake
- `w_out` out 8: updated weight
- `err_out` out 8: back-propagated error (only with `NEURON_BP_ERR_EN`)
- `out_last` out 1: marks the N_IN-th result
- `b_out` out 8: updated bias, valid from the cycle after `start` until the next `start`
- `busy` out 1: high outside IDLE
- `done` out 1: one-cycle pulse at pass end
- `ovr` out 1: sticky saturation flag for the current pass

## Operation
- Q1.6 multiply `qmul(a,b)`: 16-bit signed product, arithmetic shift right by 6, saturate to [-128,127]; saturation sets `ovr`.
- Per pair: `g = qmul(delta, x)`; `w_out = sat(w - (g >>> LR_SHIFT))`; `err_out = qmul(w, delta)`. Subtraction is done at 9 bits, then saturated.
- Bias: `b_out = sat(b - (delta >>> LR_SHIFT))`, computed on `start` acceptance.
- Any saturation sets `ovr`. It is cleared on `start` acceptance and on `rst`.
- States:
  - IDLE: `start` → STREAM; capture `delta` and `b`, compute `b_out`, clear counters and `ovr`.
  - STREAM: accept pairs, count `idx_in` accepted and `idx_out` delivered; when the output handshake with `out_last` completes → IDLE and pulse `done`.
- `start` outside IDLE is ignored.
- `in_ready = (state==STREAM) && idx_in<N_IN && (!out_valid || out_ready)`, combinational.
- Counters are `$clog2(N_IN+1)` bits. `out_last = out_valid && idx_out==N_IN-1`.

## Timing
- Reset values: `in_ready` 0, `out_valid` 0, `w_out` 0, `err_out` 0, `b_out` 0, `out_last` 0, `busy` 0, `done` 0, `ovr` 0; state IDLE.
- `rst` wins over every other input. Reset mid-pass discards the pass: no `done`, outputs return to reset values next cycle.
- `start` accepted at edge k: `busy`=1 and `b_out` valid at k+1. `in_ready` can be high at k+1.
- Pair accepted at edge k: result registered, `out_valid`=1 at k+1. Latency 1, throughput 1 pair/cycle with `out_ready` held high.
- Backpressure: while `out_valid && !out_ready`, outputs hold stable and `in_ready`=0. An input and an output handshake in the same cycle are legal.
- Final handshake at edge k: `done`=1 and `busy`=0 during cycle k+1 only. A new `start` is accepted from k+1.
- `start` coincident with `in_valid` in IDLE: only `start` is taken.

## Configuration
- `NEURON_BP_ERR_EN` defined: `err_out` port and its multiplier are present; `err_out` saturation contributes to `ovr`.
- Undefined: `err_out` port is omitted, no second multiplier, and `ovr` reflects only the weight and bias updates.

## Structure
- Shared package `nar_pkg`:
  - `DATA_W`=8, `FRAC_BITS`=6, `Q_MAX`=127, `Q_MIN`=-128
  - `q_t` signed 8-bit typedef
  - `bp_state_t` enum {IDLE, STREAM}
- Sub-module `q_mul_sat`: combinational Q1.6 saturating multiply with a sat flag. Instantiated once for the gradient and once more under `NEURON_BP_ERR_EN`.

## Test plan
- Basic update: LR_SHIFT=3, `delta`=64, `b`=10; pair w=32, x=64 → `w_out`=24, `err_out`=32, `b_out`=2, `ovr`=0.
- Saturation: `delta`=-128; pair w=-128, x=-128 → g sat 127, `w_out`=-128, `ovr`=1, and it stays 1 until the next `start`.
- Streaming: N_IN=4, `in_valid` and `out_ready` held high → 4 results on 4 consecutive cycles, `out_last` on the 4th, `done` on the following cycle.
- Backpressure: `out_ready` low for 3 cycles after the first result → `w_out`/`err_out` unchanged, `in_ready`=0, no lost or duplicated results.
- Reset mid-pass: `rst` after 2 of 4 pairs → next cycle IDLE, all outputs at reset values, no `done`; a subsequent pass produces correct results.
- Ignored `start`: `start` pulsed in STREAM with a different `delta` → results still use the original `delta`, and `b_out` is unchanged.
